// File: rtl/pd_phy_pkg.sv
// Shared constants for the USB PD reset PHY: K-codes, TRANSMIT type codes,
// one-hot transmitter states and frame lengths.
package pd_phy_pkg;

    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC3 = 5'b00110;

    localparam logic [2:0] TX_HARD_RESET  = 3'b101;
    localparam logic [2:0] TX_CABLE_RESET = 3'b110;

    localparam logic [6:0] PREAMBLE_BITS = 7'd64;
    localparam logic [6:0] ORDSET_BITS   = 7'd20;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_PREAMBLE = 5'b00010,
        ST_ORDSET   = 5'b00100,
        ST_TAIL     = 5'b01000,
        ST_DONE     = 5'b10000
    } tx_state_e;

    // Ordered-set bit at transmit position idx; K-code 0 occupies bits [4:0] so LSB goes first.
    function automatic logic ordset_bit(input logic cable, input logic [4:0] idx);
        logic [19:0] set_v;
        if (cable) begin
            set_v = {K_SYNC3, K_RST1, K_SYNC1, K_RST1};
        end else begin
            set_v = {K_RST2, K_RST1, K_RST1, K_RST1};
        end
        return set_v[idx];
    endfunction

endpackage

// File: rtl/bmc_encoder.sv
// Line-level encoder for the reset PHY. With PHY_RESET_TX_BMC_EN defined it
// produces BMC; otherwise it registers the raw NRZ bit.
module bmc_encoder (
    input  logic clk,
    input  logic reset,
    input  logic bit_val,
    input  logic bit_start,
    input  logic mid_bit,
    input  logic enable,
    output logic line
);
    logic line_q, line_d;

`ifdef PHY_RESET_TX_BMC_EN
    logic en_q;

    // Next line level: first half-bit of a frame is low, then toggle per BMC rules.
    always_comb begin
        line_d = line_q;
        if (!enable) begin
            line_d = 1'b0;
        end else if (!en_q) begin
            line_d = 1'b0;
        end else if (bit_start) begin
            line_d = ~line_q;
        end else if (mid_bit && bit_val) begin
            line_d = ~line_q;
        end else begin
            line_d = line_q;
        end
    end

    // Line and enable-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            line_q <= line_d;
            en_q   <= enable;
        end
    end
`else
    logic unused_strobes_s;
    assign unused_strobes_s = bit_start ^ mid_bit;

    // NRZ pass-through: the line simply follows the current bit while enabled.
    always_comb begin
        if (enable) begin
            line_d = bit_val;
        end else begin
            line_d = 1'b0;
        end
    end

    // Line register.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= 1'b0;
        end else begin
            line_q <= line_d;
        end
    end
`endif

    assign line = line_q;

endmodule

// File: rtl/phy_reset_tx.sv
// USB PD Hard/Cable Reset transmitter: preamble + reset ordered set on CC.
// PHY_RESET_TX_BMC_EN selects BMC line coding and the trailing TAIL bit.
module phy_reset_tx
    import pd_phy_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] iTRANSMIT,
    input  logic       tx_start,
    input  logic       PHY_Stop_Attempting_Reset,
    output logic       bmc_out,
    output logic       bmc_oe,
    output logic       tx_busy,
    output logic       PHY_ACK,
    output logic       tx_error
);
    localparam logic [7:0] HALF_LAST = 8'(HALF_BIT_CYCLES - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] half_cnt_q, half_cnt_d;
    logic       phase_q, phase_d;
    logic [6:0] bit_idx_q, bit_idx_d;
    logic       cable_q, cable_d;
    logic       busy_q, busy_d, oe_q, oe_d, ack_q, ack_d, err_q, err_d;
    logic       active_s, bit_end_s, abort_s, type_ok_s;
    logic       enc_bit_s, enc_start_s, enc_mid_s, enc_en_s;
    logic       unused_transmit_s;

    assign unused_transmit_s = ^iTRANSMIT[7:3];
    assign active_s  = (state_q == ST_PREAMBLE) || (state_q == ST_ORDSET) || (state_q == ST_TAIL);
    assign abort_s   = PHY_Stop_Attempting_Reset && active_s;
    assign type_ok_s = (iTRANSMIT[2:0] == TX_HARD_RESET) || (iTRANSMIT[2:0] == TX_CABLE_RESET);
    assign bit_end_s = (half_cnt_q == HALF_LAST) && phase_q;

    // Next-state and bit-timing counters.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        bit_idx_d  = bit_idx_q;
        cable_d    = cable_q;
        err_d      = 1'b0;
        if (abort_s) begin
            state_d    = ST_IDLE;
            half_cnt_d = 8'd0;
            phase_d    = 1'b0;
            bit_idx_d  = 7'd0;
        end else begin
            if (active_s) begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = 8'd0;
                    phase_d    = ~phase_q;
                end else begin
                    half_cnt_d = half_cnt_q + 8'd1;
                end
                if (bit_end_s) begin
                    bit_idx_d = bit_idx_q + 7'd1;
                end else begin
                    bit_idx_d = bit_idx_q;
                end
            end else begin
                half_cnt_d = half_cnt_q;
            end
            case (state_q)
                ST_IDLE: begin
                    // An abort level in IDLE swallows a simultaneous start.
                    if (PHY_Stop_Attempting_Reset) begin
                        state_d = ST_IDLE;
                    end else if (tx_start) begin
                        if (type_ok_s) begin
                            state_d    = ST_PREAMBLE;
                            cable_d    = (iTRANSMIT[2:0] == TX_CABLE_RESET);
                            half_cnt_d = 8'd0;
                            phase_d    = 1'b0;
                            bit_idx_d  = 7'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (bit_end_s && (bit_idx_q == PREAMBLE_BITS - 7'd1)) begin
                        state_d   = ST_ORDSET;
                        bit_idx_d = 7'd0;
                    end else begin
                        state_d = ST_PREAMBLE;
                    end
                end
                ST_ORDSET: begin
                    if (bit_end_s && (bit_idx_q == ORDSET_BITS - 7'd1)) begin
                        bit_idx_d = 7'd0;
`ifdef PHY_RESET_TX_BMC_EN
                        state_d   = ST_TAIL;
`else
                        state_d   = ST_DONE;
`endif
                    end else begin
                        state_d = ST_ORDSET;
                    end
                end
                ST_TAIL: begin
                    if (bit_end_s) begin
                        state_d   = ST_DONE;
                        bit_idx_d = 7'd0;
                    end else begin
                        state_d = ST_TAIL;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: begin
                    state_d    = ST_IDLE;
                    half_cnt_d = 8'd0;
                    phase_d    = 1'b0;
                    bit_idx_d  = 7'd0;
                end
            endcase
        end
    end

    // Outputs and encoder strobes are derived from next state so they land registered.
    always_comb begin
        busy_d      = (state_d == ST_PREAMBLE) || (state_d == ST_ORDSET) || (state_d == ST_TAIL);
        oe_d        = busy_d;
        ack_d       = (state_d == ST_DONE);
        enc_en_s    = (state_d == ST_PREAMBLE) || (state_d == ST_ORDSET);
        if (state_d == ST_PREAMBLE) begin
            enc_bit_s = bit_idx_d[0];
        end else if (state_d == ST_ORDSET) begin
            enc_bit_s = ordset_bit(cable_d, bit_idx_d[4:0]);
        end else begin
            enc_bit_s = 1'b0;
        end
        enc_start_s = enc_en_s && (half_cnt_d == 8'd0) && !phase_d;
        enc_mid_s   = enc_en_s && (half_cnt_d == 8'd0) && phase_d;
    end

    // State, counter and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            half_cnt_q <= 8'd0;
            phase_q    <= 1'b0;
            bit_idx_q  <= 7'd0;
            cable_q    <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            cable_q    <= cable_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    bmc_encoder u_bmc_encoder (
        .clk       (CLK),
        .reset     (reset),
        .bit_val   (enc_bit_s),
        .bit_start (enc_start_s),
        .mid_bit   (enc_mid_s),
        .enable    (enc_en_s),
        .line      (bmc_out)
    );

    assign bmc_oe   = oe_q;
    assign tx_busy  = busy_q;
    assign PHY_ACK  = ack_q;
    assign tx_error = err_q;

endmodule

// File: tb/tb_phy_reset_tx.sv
// Self-checking bench for phy_reset_tx: decodes the captured CC line and
// compares it with a frame model built from K-code tables.
module tb_phy_reset_tx;
    localparam int H       = 4;
    localparam int BIT_CYC = 2 * H;
`ifdef PHY_RESET_TX_BMC_EN
    localparam int FRAME_BITS = 85;
`else
    localparam int FRAME_BITS = 84;
`endif
    localparam int DATA_BITS = 84;
    localparam int DONE_CYC  = 1 + FRAME_BITS * BIT_CYC;
    localparam int MAXC      = DONE_CYC + 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] iTRANSMIT;
    logic       tx_start;
    logic       stop;
    logic       bmc_out, bmc_oe, tx_busy, PHY_ACK, tx_error;

    logic obs_out  [0:MAXC];
    logic obs_oe   [0:MAXC];
    logic obs_busy [0:MAXC];
    logic obs_ack  [0:MAXC];
    logic obs_err  [0:MAXC];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    phy_reset_tx #(.HALF_BIT_CYCLES(H)) dut (
        .CLK                       (clk),
        .reset                     (reset),
        .iTRANSMIT                 (iTRANSMIT),
        .tx_start                  (tx_start),
        .PHY_Stop_Attempting_Reset (stop),
        .bmc_out                   (bmc_out),
        .bmc_oe                    (bmc_oe),
        .tx_busy                   (tx_busy),
        .PHY_ACK                   (PHY_ACK),
        .tx_error                  (tx_error)
    );

    // Reference: bit k of the frame in transmit order.
    function automatic logic exp_bit(input logic cable, input int k);
        logic [4:0] seq [4];
        int j;
        if (cable) seq = '{5'b00111, 5'b11000, 5'b00111, 5'b00110};
        else       seq = '{5'b00111, 5'b00111, 5'b00111, 5'b11001};
        if (k < 64) return (k % 2) == 1;
        j = k - 64;
        return seq[j / 5][j % 5];
    endfunction

    // Start request at edge 0, then record cycles 1..MAXC; event inputs fire during cycle N.
    task automatic capture(input logic [7:0] tx, input logic stop_with_start,
                           input int abort_at, input int extra_at, input int reset_at);
        @(negedge clk);
        iTRANSMIT = tx;
        tx_start  = 1'b1;
        stop      = stop_with_start;
        for (int c = 1; c <= MAXC; c++) begin
            @(negedge clk);
            obs_out[c]  = bmc_out;
            obs_oe[c]   = bmc_oe;
            obs_busy[c] = tx_busy;
            obs_ack[c]  = PHY_ACK;
            obs_err[c]  = tx_error;
            tx_start = (c == extra_at);
            stop     = (c == abort_at);
            reset    = (c == reset_at);
        end
        tx_start = 1'b0;
        stop     = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({bmc_out, bmc_oe, tx_busy, PHY_ACK, tx_error} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b expected 00000", {bmc_out, bmc_oe, tx_busy, PHY_ACK, tx_error});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bmc_out, bmc_oe, tx_busy, PHY_ACK, tx_error} !== 5'b0) begin
            n_fail++; $display("FAIL idle_outputs got %b expected 00000", {bmc_out, bmc_oe, tx_busy, PHY_ACK, tx_error});
        end
    endtask

    task automatic test_frames();
        logic [7:0] txs [6];
        int extras [6];
        logic [DATA_BITS-1:0] dec, expv;
        int viol, ack_cnt, ack_at, oe_bad, busy_bad, err_cnt, tail_bad, base;
        logic cable, h1, h2;
        txs[0] = 8'h05; txs[1] = 8'hF6; txs[5] = 8'h05;
        for (int i = 2; i <= 4; i++)
            txs[i] = {5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b101};
        for (int i = 0; i < 6; i++) extras[i] = 0;
        extras[5] = 100;
        for (int f = 0; f < 6; f++) begin
            cable = (txs[f][2:0] == 3'b110);
            capture(txs[f], 1'b0, 0, extras[f], 0);
            viol = 0;
            for (int k = 0; k < DATA_BITS; k++) begin
                base    = 1 + k * BIT_CYC;
                expv[k] = exp_bit(cable, k);
`ifdef PHY_RESET_TX_BMC_EN
                h1 = obs_out[base];
                h2 = obs_out[base + H];
                for (int j = 0; j < H; j++) begin
                    if (obs_out[base + j] !== h1) viol++;
                    if (obs_out[base + H + j] !== h2) viol++;
                end
                dec[k] = h1 ^ h2;
                if (k == 0) begin
                    if (obs_out[base] !== 1'b0) viol++;
                end else if (obs_out[base] === obs_out[base - 1]) viol++;
`else
                for (int j = 0; j < BIT_CYC; j++)
                    if (obs_out[base + j] !== obs_out[base]) viol++;
                dec[k] = obs_out[base];
`endif
            end
            tail_bad = 0; ack_cnt = 0; ack_at = -1; oe_bad = 0; busy_bad = 0; err_cnt = 0;
            for (int c = 1 + DATA_BITS * BIT_CYC; c <= MAXC; c++)
                if (obs_out[c] !== 1'b0) tail_bad++;
            for (int c = 1; c <= MAXC; c++) begin
                if (obs_ack[c] === 1'b1) begin ack_cnt++; ack_at = c; end
                if (obs_oe[c] !== (c < DONE_CYC)) oe_bad++;
                if (obs_busy[c] !== (c < DONE_CYC)) busy_bad++;
                if (obs_err[c] !== 1'b0) err_cnt++;
            end
            n_checks++; if (dec !== expv) begin
                n_fail++; $display("FAIL frame%0d bits got %h expected %h", f, dec, expv);
            end
            n_checks++; if (viol !== 0) begin
                n_fail++; $display("FAIL frame%0d line_coding violations got %0d expected 0", f, viol);
            end
            n_checks++; if (tail_bad !== 0) begin
                n_fail++; $display("FAIL frame%0d tail_low nonzero samples got %0d expected 0", f, tail_bad);
            end
            n_checks++; if (ack_cnt !== 1 || ack_at !== DONE_CYC) begin
                n_fail++; $display("FAIL frame%0d ack got count %0d at cycle %0d expected 1 at %0d", f, ack_cnt, ack_at, DONE_CYC);
            end
            n_checks++; if (oe_bad !== 0 || busy_bad !== 0) begin
                n_fail++; $display("FAIL frame%0d oe/busy window errors got %0d/%0d expected 0/0", f, oe_bad, busy_bad);
            end
            n_checks++; if (err_cnt !== 0) begin
                n_fail++; $display("FAIL frame%0d tx_error pulses got %0d expected 0", f, err_cnt);
            end
        end
    endtask

    task automatic test_invalid();
        logic [2:0] bad [6];
        logic [7:0] tx;
        int err_cnt, act_cnt;
        bad = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        for (int t = 0; t < 3; t++) begin
            tx = (t == 0) ? 8'h03 : {5'($urandom_range(0, 31)), bad[$urandom_range(0, 5)]};
            capture(tx, 1'b0, 0, 0, 0);
            err_cnt = 0; act_cnt = 0;
            for (int c = 1; c <= 40; c++) begin
                if (obs_err[c] === 1'b1) err_cnt++;
                if (obs_busy[c] !== 1'b0 || obs_oe[c] !== 1'b0 || obs_ack[c] !== 1'b0 || obs_out[c] !== 1'b0) act_cnt++;
            end
            n_checks++; if (obs_err[1] !== 1'b1 || err_cnt !== 1) begin
                n_fail++; $display("FAIL invalid%0d tx_error cycle1 %b count %0d expected 1 and 1", t, obs_err[1], err_cnt);
            end
            n_checks++; if (act_cnt !== 0) begin
                n_fail++; $display("FAIL invalid%0d activity cycles got %0d expected 0", t, act_cnt);
            end
        end
    endtask

    task automatic test_abort();
        int a, ack_cnt, oe_cnt;
        for (int t = 0; t < 2; t++) begin
            a = (t == 0) ? 300 : int'($urandom_range(1, DONE_CYC - 1));
            capture(8'h05, 1'b0, a, 0, 0);
            ack_cnt = 0; oe_cnt = 0;
            for (int c = 1; c <= MAXC; c++) begin
                if (obs_ack[c] === 1'b1) ack_cnt++;
                if (obs_oe[c] === 1'b1) oe_cnt++;
            end
            n_checks++; if ({obs_out[a + 1], obs_oe[a + 1], obs_busy[a + 1]} !== 3'b000) begin
                n_fail++; $display("FAIL abort@%0d out/oe/busy got %b expected 000", a, {obs_out[a + 1], obs_oe[a + 1], obs_busy[a + 1]});
            end
            n_checks++; if (ack_cnt !== 0 || oe_cnt !== a) begin
                n_fail++; $display("FAIL abort@%0d ack count %0d oe cycles %0d expected 0 and %0d", a, ack_cnt, oe_cnt, a);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ack_cnt, oe_cnt;
        capture(8'h05, 1'b0, 0, 0, 200);
        ack_cnt = 0; oe_cnt = 0;
        for (int c = 1; c <= MAXC; c++) begin
            if (obs_ack[c] === 1'b1) ack_cnt++;
            if (obs_oe[c] === 1'b1) oe_cnt++;
        end
        n_checks++; if ({obs_out[201], obs_oe[201], obs_busy[201], obs_ack[201], obs_err[201]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mid cycle201 outputs got %b expected 00000",
                               {obs_out[201], obs_oe[201], obs_busy[201], obs_ack[201], obs_err[201]});
        end
        n_checks++; if (ack_cnt !== 0 || oe_cnt !== 200) begin
            n_fail++; $display("FAIL reset_mid ack count %0d oe cycles %0d expected 0 and 200", ack_cnt, oe_cnt);
        end
    endtask

    task automatic test_abort_blocks_start();
        int act_cnt;
        capture(8'h06, 1'b1, 0, 0, 0);
        act_cnt = 0;
        for (int c = 1; c <= 40; c++)
            if (obs_busy[c] !== 1'b0 || obs_oe[c] !== 1'b0 || obs_err[c] !== 1'b0) act_cnt++;
        n_checks++; if (act_cnt !== 0) begin
            n_fail++; $display("FAIL idle_abort_start activity cycles got %0d expected 0", act_cnt);
        end
    endtask

    initial begin
        reset     = 1'b1;
        iTRANSMIT = 8'h00;
        tx_start  = 1'b0;
        stop      = 1'b0;
        test_reset();
        test_frames();
        test_invalid();
        test_abort();
        test_reset_mid();
        test_abort_blocks_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_reset_tx.md
# phy_reset_tx

Physical-layer transmitter for USB PD Hard Reset and Cable Reset signalling, sitting directly downstream of the hard-reset protocol layer. On a start request it emits the 64-bit preamble followed by the 4-K-code reset ordered set on the CC line, BMC-encoded. It then returns a one-cycle `PHY_ACK` to the protocol layer. An upstream `PHY_Stop_Attempting_Reset` aborts transmission immediately.

## Interface
- `HALF_BIT_CYCLES`, default 4: CLK cycles per BMC half-bit; legal range 2..255.
- `CLK` input 1: single clock; all logic is posedge.
- `reset` input 1: synchronous, active-high.
- `iTRANSMIT` input 8: TRANSMIT register image. Bits [2:0] select the reset type: 3'b101 = Hard Reset, 3'b110 = Cable Reset. Bits [7:3] are ignored.
- `tx_start` input 1: single-cycle request; sampled only in IDLE.
- `PHY_Stop_Attempting_Reset` input 1: level abort from the protocol layer.
- `bmc_out` output 1: CC line data.
- `bmc_oe` output 1: CC driver enable.
- `tx_busy` output 1: high from the cycle after an accepted start until the cycle `PHY_ACK` pulses, or until an abort takes effect.
- `PHY_ACK` output 1: one-cycle pulse on successful completion.
- `tx_error` output 1: one-cycle pulse when a start request is rejected.

## Operation
- Reset values: all outputs 0, state IDLE, all counters 0.
- States: IDLE -> PREAMBLE -> ORDSET -> TAIL -> DONE -> IDLE.
- Start acceptance:
  - `tx_start` in IDLE with a valid `iTRANSMIT[2:0]` latches the type and moves to PREAMBLE.
  - An invalid type stays in IDLE and pulses `tx_error` in the next cycle.
  - `tx_start` outside IDLE is ignored, with no error.
- PREAMBLE: 64 bits alternating, starting with 0 (bit 0 = 0, bit 63 = 1).
- ORDSET: 4 K-codes of 5 bits each, sent LSB first, 20 bits total.
  - Hard Reset: RST-1, RST-1, RST-1, RST-2.
  - Cable Reset: RST-1, Sync-1, RST-1, Sync-3.
  - Codes: RST-1 = 5'b00111, RST-2 = 5'b11001, Sync-1 = 5'b11000, Sync-3 = 5'b00110.
- BMC encoding:
  - The line inverts at the start of every bit.
  - For a 1 bit it also inverts at mid-bit.
  - The line starts low when leaving IDLE.
- TAIL: `bmc_out` = 0 and `bmc_oe` = 1 for one full bit period.
- DONE: lasts one cycle.
  - `PHY_ACK` = 1, `tx_busy` = 0, `bmc_oe` = 0.
  - Next state is IDLE.
- Abort: `PHY_Stop_Attempting_Reset` high in any cycle while busy.
  - The next cycle is IDLE with `bmc_out` = 0, `bmc_oe` = 0, `tx_busy` = 0.
  - No `PHY_ACK` is issued.
- Abort in IDLE blocks a simultaneous `tx_start`. The start is not accepted and no `tx_error` is raised.
- A `reset` asserted mid-transmission returns every output to its reset value in the next cycle.

## Timing
- A start accepted at edge 0 gives the first half-bit in cycle 1.
- Each bit lasts 2×`HALF_BIT_CYCLES` cycles. Counter widths: half-bit counter 8 bits, bit index 7 bits.
- `PHY_ACK` fires at cycle 1 + 85×2×`HALF_BIT_CYCLES`, which is cycle 681 for H = 4.
- `bmc_oe` is high over cycles 1..680 for H = 4.
- Abort latency is exactly 1 cycle.

## Configuration
- Macro: `PHY_RESET_TX_BMC_EN`.
- Defined:
  - BMC encoding as described above.
  - TAIL state present.
- Undefined:
  - `bmc_out` carries the raw NRZ bit, held for the full bit period with no transitions.
  - TAIL is skipped, so `PHY_ACK` fires at cycle 1 + 84×2×`HALF_BIT_CYCLES` (673 for H = 4).
  - Ports are unchanged.

## Structure
- Shared package `pd_phy_pkg`:
  - K-code localparams.
  - TRANSMIT type codes (3'b101, 3'b110).
  - One-hot state encodings.
  - Preamble length 64 and ordered-set length 20.
- One sub-module, `bmc_encoder`:
  - Inputs: bit value, bit-start strobe, mid-bit strobe, enable.
  - Output: line level.
  - Compiled as a pass-through when `PHY_RESET_TX_BMC_EN` is undefined.

## Test plan
- Hard Reset, H = 4:
  - Stimulus: `tx_start` with `iTRANSMIT` = 8'h05.
  - Decoded bits must be 64 alternating bits, then 11100 11100 11100 10011.
  - `PHY_ACK` pulses once at cycle 681.
  - `bmc_oe` is high for exactly 680 cycles.
- Cable Reset:
  - Stimulus: `iTRANSMIT` = 8'hF6 (upper bits ignored).
  - Decoded ordered set must be 11100 00011 11100 01100.
  - `PHY_ACK` at cycle 681.
- Invalid type:
  - Stimulus: `iTRANSMIT` = 8'h03 with `tx_start`.
  - `tx_error` pulses in cycle 1, `tx_busy` stays 0, `bmc_oe` stays 0.
- Abort:
  - Stimulus: `PHY_Stop_Attempting_Reset` = 1 at cycle 300.
  - Cycle 301 shows `bmc_oe` = 0, `tx_busy` = 0, `bmc_out` = 0, and `PHY_ACK` never asserts.
- Second `tx_start` at cycle 100 while busy:
  - It is ignored and the frame timing is unchanged.
  - A `reset` pulse at cycle 200 zeroes all outputs in cycle 201.
- With `PHY_RESET_TX_BMC_EN` undefined:
  - The same Hard Reset stimulus yields NRZ bits matching the first test.
  - `PHY_ACK` at cycle 673.
